// File: rtl/player_ctrl_if.sv
// Control/status bundle between the input debouncer, player_ctrl and the
// bullet/sprite renderers.
interface player_ctrl_if #(
  parameter int unsigned X_WIDTH     = 10,
  parameter int unsigned LIVES_WIDTH = 2
);
  logic                   frame;
  logic                   left;
  logic                   right;
  logic                   fire;
  logic                   hit;
  logic [X_WIDTH-1:0]     player_x;
  logic [X_WIDTH-1:0]     player_y;
  logic                   shot_req;
  logic [X_WIDTH-1:0]     shot_x;
  logic [LIVES_WIDTH-1:0] lives;
  logic                   alive;
  logic                   game_over;

  modport master (
    output frame, left, right, fire, hit,
    input  player_x, player_y, shot_req, shot_x, lives, alive, game_over
  );

  modport slave (
    input  frame, left, right, fire, hit,
    output player_x, player_y, shot_req, shot_x, lives, alive, game_over
  );
endinterface

// File: rtl/player_ctrl.sv
// Frame-synchronous cannon controller: sticky inputs, clamped per-frame moves,
// rate-limited shots and the alive/dying/over life cycle.
module player_ctrl #(
  parameter int unsigned X_WIDTH       = 10,
  parameter int unsigned START_X       = 304,
  parameter int unsigned START_Y       = 440,
  parameter int unsigned STEP          = 2,
  parameter int unsigned MIN_X         = 16,
  parameter int unsigned MAX_X         = 608,
  parameter int unsigned FIRE_COOLDOWN = 8,
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned LIVES_WIDTH   = 2,
  parameter int unsigned SHOT_OFFSET   = 15
) (
  input logic           clk,
  input logic           rst,
  player_ctrl_if.slave  bus
);

  localparam int unsigned CdW = $clog2(FIRE_COOLDOWN + 1);
  localparam int unsigned DcW = $clog2(DEATH_FRAMES + 1);

  typedef logic [X_WIDTH:0] xe_t;
  localparam xe_t MinX = xe_t'(MIN_X);
  localparam xe_t MaxX = xe_t'(MAX_X);
  localparam xe_t Step = xe_t'(STEP);

  typedef enum logic [1:0] {StAlive, StDying, StOver} state_e;

  state_e                 state_q, state_d;
  logic [X_WIDTH-1:0]     x_q, x_d;
  logic [X_WIDTH-1:0]     shot_x_q, shot_x_d;
  logic                   shot_req_q, shot_req_d;
  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic [CdW-1:0]         cd_q, cd_d;
  logic [DcW-1:0]         death_q, death_d;
  logic                   stk_l_q, stk_l_d, stk_r_q, stk_r_d, stk_f_q, stk_f_d;

  logic eff_l, eff_r, eff_f;
  xe_t  x_ext;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    shot_x_d   = shot_x_q;
    shot_req_d = 1'b0;
    lives_d    = lives_q;
    cd_d       = cd_q;
    death_d    = death_q;
    eff_l      = stk_l_q | bus.left;
    eff_r      = stk_r_q | bus.right;
    eff_f      = stk_f_q | bus.fire;
    x_ext      = {1'b0, x_q};
    // Flags collect input between frames and restart on every frame cycle.
    stk_l_d    = bus.frame ? 1'b0 : eff_l;
    stk_r_d    = bus.frame ? 1'b0 : eff_r;
    stk_f_d    = bus.frame ? 1'b0 : eff_f;

    case (state_q)
      StAlive: begin
        if (bus.hit) begin
          lives_d = lives_q - 1'b1;
          if (lives_q == LIVES_WIDTH'(1)) begin
            state_d = StOver;
          end else begin
            state_d = StDying;
            death_d = DcW'(DEATH_FRAMES);
          end
        end else if (bus.frame) begin
          if (eff_l && !eff_r) begin
            x_d = (x_ext >= MinX + Step) ? X_WIDTH'(x_ext - Step) : X_WIDTH'(MIN_X);
          end else if (eff_r && !eff_l) begin
            x_d = (x_ext + Step <= MaxX) ? X_WIDTH'(x_ext + Step) : X_WIDTH'(MAX_X);
          end
          if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
          end else if (eff_f) begin
            shot_req_d = 1'b1;
            shot_x_d   = x_q + X_WIDTH'(SHOT_OFFSET);
            cd_d       = CdW'(FIRE_COOLDOWN - 1);
          end
        end
      end
      StDying: begin
        if (bus.frame) begin
          if (death_q == DcW'(1)) begin
            state_d = StAlive;
            x_d     = X_WIDTH'(START_X);
            cd_d    = '0;
            death_d = '0;
          end else begin
            death_d = death_q - 1'b1;
          end
        end
      end
      StOver: begin
      end
      default: state_d = StAlive;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StAlive;
      x_q        <= X_WIDTH'(START_X);
      shot_x_q   <= '0;
      shot_req_q <= 1'b0;
      lives_q    <= LIVES_WIDTH'(LIVES);
      cd_q       <= '0;
      death_q    <= '0;
      stk_l_q    <= 1'b0;
      stk_r_q    <= 1'b0;
      stk_f_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      shot_x_q   <= shot_x_d;
      shot_req_q <= shot_req_d;
      lives_q    <= lives_d;
      cd_q       <= cd_d;
      death_q    <= death_d;
      stk_l_q    <= stk_l_d;
      stk_r_q    <= stk_r_d;
      stk_f_q    <= stk_f_d;
    end
  end

  assign bus.player_x  = x_q;
  assign bus.player_y  = X_WIDTH'(START_Y);
  assign bus.shot_req  = shot_req_q;
  assign bus.shot_x    = shot_x_q;
  assign bus.lives     = lives_q;
  assign bus.alive     = (state_q == StAlive);
  assign bus.game_over = (state_q == StOver);

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: expectations are queued with the stimulus
// and compared one cycle later, after the clock edge.
module tb_player_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  player_ctrl_if #(.X_WIDTH(10), .LIVES_WIDTH(2)) bus ();

  player_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string tag;
    int    x;
    int    shot;
    int    sx;
    int    lives;
    int    alive;
    int    over;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int x, input int shot, input int sx,
                      input int lives, input int alive, input int over);
    exp_t e;
    e.tag = tag; e.x = x; e.shot = shot; e.sx = sx;
    e.lives = lives; e.alive = alive; e.over = over;
    sb.push_back(e);
  endtask

  // Negative fields are don't-care.
  task automatic pop_cmp();
    exp_t e;
    e = sb.pop_front();
    if (e.x >= 0) check_val({e.tag, ".x"}, 32'(bus.player_x), e.x);
    check_val({e.tag, ".y"}, 32'(bus.player_y), 440);
    if (e.shot >= 0) check_val({e.tag, ".shot_req"}, 32'(bus.shot_req), e.shot);
    if (e.sx >= 0) check_val({e.tag, ".shot_x"}, 32'(bus.shot_x), e.sx);
    check_val({e.tag, ".lives"}, 32'(bus.lives), e.lives);
    check_val({e.tag, ".alive"}, 32'(bus.alive), e.alive);
    check_val({e.tag, ".game_over"}, 32'(bus.game_over), e.over);
  endtask

  task automatic do_cycle(input bit f, input bit l, input bit r, input bit fi, input bit h);
    bus.frame = f; bus.left = l; bus.right = r; bus.fire = fi; bus.hit = h;
    @(posedge clk);
    #1;
    if (sb.size() > 0) pop_cmp();
  endtask

  task automatic run_frame(input bit l, input bit r, input bit fi, input bit chk,
                           input string tag, input int x, input int shot, input int sx,
                           input int lives, input int alive, input int over);
    do_cycle(1'b0, l, r, fi, 1'b0);
    do_cycle(1'b0, l, r, fi, 1'b0);
    if (chk) push(tag, x, shot, sx, lives, alive, over);
    do_cycle(1'b1, l, r, fi, 1'b0);
  endtask

  initial begin
    bus.frame = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.fire = 1'b0; bus.hit = 1'b0;
    do_cycle(0, 0, 0, 0, 0);
    push("reset", 304, 0, 0, 3, 1, 0);
    do_cycle(0, 0, 0, 0, 0);
    rst = 1'b1;

    // Fire held: shots on frames 1, 9, 17 from x=304.
    for (int i = 1; i <= 20; i++) begin
      bit s;
      s = (i == 1) || (i == 9) || (i == 17);
      run_frame(0, 0, 1, 1, "fire_held", 304, int'(s), s ? 319 : -1, 3, 1, 0);
      if (i == 1) push("shot_one_cycle", 304, 0, -1, 3, 1, 0);
    end
    for (int i = 0; i < 4; i++) run_frame(0, 0, 0, 0, "", 0, 0, 0, 0, 0, 0);

    // Single-cycle fire between frames is remembered; a second one in cooldown is not.
    do_cycle(0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 0);
    do_cycle(0, 0, 0, 0, 0);
    push("fire_pulse", 304, 1, 319, 3, 1, 0);
    do_cycle(1, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 0);
    push("fire_pulse_cooldown", 304, 0, -1, 3, 1, 0);
    do_cycle(1, 0, 0, 0, 0);

    for (int i = 1; i <= 5; i++) run_frame(0, 1, 0, 1, "right", 304 + 2 * i, 0, -1, 3, 1, 0);
    for (int i = 1; i <= 5; i++) run_frame(1, 1, 0, 1, "both", 314, 0, -1, 3, 1, 0);

    for (int i = 0; i < 148; i++) run_frame(1, 0, 0, 0, "", 0, 0, 0, 0, 0, 0);
    push("at_18", 18, 0, -1, 3, 1, 0);
    do_cycle(0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) run_frame(1, 0, 0, 1, "clamp_min", 16, 0, -1, 3, 1, 0);
    for (int i = 0; i < 295; i++) run_frame(0, 1, 0, 0, "", 0, 0, 0, 0, 0, 0);
    push("at_606", 606, 0, -1, 3, 1, 0);
    do_cycle(0, 0, 0, 0, 0);
    for (int i = 1; i <= 2; i++) run_frame(0, 1, 0, 1, "clamp_max", 608, 0, -1, 3, 1, 0);

    // First hit, then 60 dying frames with inputs held and a second hit ignored.
    push("hit1", 608, 0, -1, 2, 0, 0);
    do_cycle(0, 0, 0, 0, 1);
    for (int i = 1; i <= 60; i++) begin
      if (i == 10) begin
        push("hit_while_dying", 608, 0, -1, 2, 0, 0);
        do_cycle(0, 0, 0, 0, 1);
      end
      run_frame(0, 1, 1, 1, "dying", (i == 60) ? 304 : 608, 0, -1, 2, int'(i == 60), 0);
    end

    push("hit2", 304, 0, -1, 1, 0, 0);
    do_cycle(0, 0, 0, 0, 1);
    for (int i = 1; i <= 60; i++) run_frame(0, 0, 0, i == 60, "respawn2", 304, 0, -1, 1, 1, 0);

    // Final hit coincides with a frame: no move, no shot, straight to game over.
    push("hit3", 304, 0, -1, 0, 0, 1);
    do_cycle(1, 0, 1, 1, 1);
    for (int i = 1; i <= 3; i++) run_frame(0, 1, 1, 1, "over_frozen", 304, 0, -1, 0, 0, 1);
    do_cycle(0, 0, 0, 1, 1);

    // Asynchronous reset takes effect without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    push("async_rst_over", 304, 0, 0, 3, 1, 0);
    pop_cmp();
    do_cycle(0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 1; i <= 2; i++) run_frame(0, 1, 0, 1, "post_rst", 304 + 2 * i, 0, -1, 3, 1, 0);
    push("hit_pre_rst", 308, 0, -1, 2, 0, 0);
    do_cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) run_frame(0, 0, 0, 0, "", 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    push("async_rst_dying", 304, 0, 0, 3, 1, 0);
    pop_cmp();
    do_cycle(0, 0, 0, 0, 0);
    rst = 1'b1;
    run_frame(0, 1, 0, 1, "after_rst_move", 306, 0, -1, 3, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
